// File: rtl/icache_refill_unit_pkg.sv
// Shared constants and state encoding for the instruction-cache refill path.
// The width macros are provided here only when no project-wide definition exists.
`ifndef PC_SIZE
`define PC_SIZE 32
`endif
`ifndef MEMORY_WORD
`define MEMORY_WORD 32
`endif

package icache_refill_unit_pkg;

  // Line size shared with fetch_unit's cache so both sides agree on the line geometry.
  localparam int icache_line_words = 16;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    DRAIN,
    DONE
  } refill_state_t;

endpackage

// File: rtl/icache_refill_unit.sv
// Instruction-cache refill controller: fetches one line, critical word first, one
// outstanding request at a time, and streams each word to the fetch unit as it lands.
module icache_refill_unit
  import icache_refill_unit_pkg::*;
#(
  parameter int ADDR_W     = `PC_SIZE,
  parameter int WORD_W     = `MEMORY_WORD,
  parameter int LINE_WORDS = icache_line_words,
  localparam int IDX_W     = $clog2(LINE_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              miss_cache,
  input  logic [ADDR_W-1:0] ram_address,
  output logic [WORD_W-1:0] mem_word,
  output logic              word_ready,
  output logic [IDX_W-1:0]  word_idx,
  output logic              refill_done,
  output logic              busy,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata
);

  refill_state_t     state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [IDX_W-1:0]  cnt_q, cnt_d;
  logic              armed_q, armed_d;

  logic [WORD_W-1:0] mem_word_q, mem_word_d;
  logic              word_ready_q, word_ready_d;
  logic [IDX_W-1:0]  word_idx_q, word_idx_d;
  logic              refill_done_q, refill_done_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

  logic [IDX_W-1:0]  idx_inc;
  logic              last_word;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [IDX_W-1:0]  idx);
    return base | {{(ADDR_W-IDX_W){1'b0}}, idx};
  endfunction

  // Index wraps inside the line, so a critical-word-first fetch visits every slot once.
  assign idx_inc   = idx_q + IDX_W'(1);
  assign last_word = (cnt_q == IDX_W'(LINE_WORDS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      idx_q         <= '0;
      cnt_q         <= '0;
      armed_q       <= 1'b1;
      mem_word_q    <= '0;
      word_ready_q  <= 1'b0;
      word_idx_q    <= '0;
      refill_done_q <= 1'b0;
      busy_q        <= 1'b0;
      mem_req_q     <= 1'b0;
      mem_addr_q    <= '0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      armed_q       <= armed_d;
      mem_word_q    <= mem_word_d;
      word_ready_q  <= word_ready_d;
      word_idx_q    <= word_idx_d;
      refill_done_q <= refill_done_d;
      busy_q        <= busy_d;
      mem_req_q     <= mem_req_d;
      mem_addr_q    <= mem_addr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (miss_cache && armed_q) state_d = REQ;
      REQ: begin
        if (!miss_cache)  state_d = mem_gnt ? DRAIN : IDLE;
        else if (mem_gnt) state_d = WAIT;
      end
      WAIT: begin
        if (!miss_cache)     state_d = mem_rvalid ? IDLE : DRAIN;
        else if (mem_rvalid) state_d = last_word ? DONE : REQ;
      end
      DRAIN: if (mem_rvalid) state_d = IDLE;
      DONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Any sampled low on miss_cache re-arms; a miss held high across refill_done does not retrigger.
  always_comb begin
    base_d        = base_q;
    idx_d         = idx_q;
    cnt_d         = cnt_q;
    armed_d       = armed_q | ~miss_cache;
    mem_word_d    = mem_word_q;
    word_idx_d    = word_idx_q;
    word_ready_d  = 1'b0;
    refill_done_d = 1'b0;
    mem_req_d     = mem_req_q;
    mem_addr_d    = mem_addr_q;
    busy_d        = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (miss_cache && armed_q) begin
          base_d     = {ram_address[ADDR_W-1:IDX_W], {IDX_W{1'b0}}};
          idx_d      = ram_address[IDX_W-1:0];
          cnt_d      = '0;
          armed_d    = 1'b0;
          mem_req_d  = 1'b1;
          mem_addr_d = ram_address;
        end
      end
      REQ: begin
        if (mem_gnt || !miss_cache) mem_req_d = 1'b0;
      end
      WAIT: begin
        if (mem_rvalid && miss_cache) begin
          word_ready_d = 1'b1;
          mem_word_d   = mem_rdata;
          word_idx_d   = idx_q;
          idx_d        = idx_inc;
          cnt_d        = cnt_q + IDX_W'(1);
          if (!last_word) begin
            mem_req_d  = 1'b1;
            mem_addr_d = line_addr(base_q, idx_inc);
          end
        end
      end
      DONE:    refill_done_d = 1'b1;
      default: ;
    endcase
  end

  assign mem_word    = mem_word_q;
  assign word_ready  = word_ready_q;
  assign word_idx    = word_idx_q;
  assign refill_done = refill_done_q;
  assign busy        = busy_q;
  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;

endmodule

// File: tb/tb_icache_refill_unit.sv
// Directed bench for icache_refill_unit with a behavioural request/grant/rvalid memory.
module tb_icache_refill_unit;

  localparam int AW = 32;
  localparam int WW = 32;
  localparam int LW = 16;
  localparam int IW = 4;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          miss_cache = 1'b0;
  logic [AW-1:0] ram_address = '0;
  logic [WW-1:0] mem_word;
  logic          word_ready;
  logic [IW-1:0] word_idx;
  logic          refill_done;
  logic          busy;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [WW-1:0] mem_rdata = '0;

  icache_refill_unit #(.ADDR_W(AW), .WORD_W(WW), .LINE_WORDS(LW)) dut (
    .clk(clk), .rst(rst), .miss_cache(miss_cache), .ram_address(ram_address),
    .mem_word(mem_word), .word_ready(word_ready), .word_idx(word_idx),
    .refill_done(refill_done), .busy(busy), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] addr;
    int          gnt_stall;
    int          rv_dly;
    int          first_idx;
    logic [31:0] first_addr;
    int          spacing;
  } vec_t;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int gnt_stall = 0, rv_dly = 0, stall_cnt = 0, rv_cnt = 0;
  bit pend = 1'b0;
  logic [31:0] pend_addr = '0;
  bit held_req = 1'b0;
  logic [31:0] held_addr = '0;
  int widx_q[$];
  logic [31:0] wdat_q[$];
  int wcyc_q[$];
  logic [31:0] addr_q[$];
  int done_cnt = 0, done_cyc = 0, first_req_cyc = -1, last_wr_cyc = -10;
  int exp_req = 0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // One clock: observe at the falling edge, then drive the memory side for the next rising edge.
  task automatic cycle();
    @(negedge clk);
    if (held_req && miss_cache && !rst) begin
      chk("req_hold", int'(mem_req), 1);
      chk("addr_hold", mem_addr, held_addr);
    end
    if (word_ready) begin
      chk("ready_gap", int'((cyc - last_wr_cyc) > 1), 1);
      chk("ready_done_excl", int'(refill_done), 0);
      widx_q.push_back(int'(word_idx));
      wdat_q.push_back(mem_word);
      wcyc_q.push_back(cyc);
      last_wr_cyc = cyc;
    end
    if (refill_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (mem_req && first_req_cyc < 0) first_req_cyc = cyc;
    mem_gnt = 1'b0;
    mem_rvalid = 1'b0;
    if (pend) begin
      if (rv_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata = pend_addr ^ KEY;
        pend = 1'b0;
      end else rv_cnt--;
    end
    if (mem_req && !pend) begin
      if (stall_cnt < gnt_stall) stall_cnt++;
      else begin
        mem_gnt = 1'b1;
        pend = 1'b1;
        pend_addr = mem_addr;
        rv_cnt = rv_dly;
        stall_cnt = 0;
        addr_q.push_back(mem_addr);
      end
    end
    held_req = mem_req && !mem_gnt;
    held_addr = mem_addr;
    cyc++;
  endtask

  task automatic clear_obs();
    widx_q.delete();
    wdat_q.delete();
    wcyc_q.delete();
    addr_q.delete();
    done_cnt = 0;
    first_req_cyc = -1;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done_cnt == 0 && n < 800) begin
      cycle();
      n++;
    end
    chk({nm, "_done_seen"}, int'(done_cnt != 0), 1);
  endtask

  task automatic check_line(input string nm, input logic [31:0] addr, input int first_idx,
                            input logic [31:0] first_addr, input int spacing);
    logic [31:0] base;
    logic [31:0] ea;
    int idx;
    base = addr & 32'hFFFF_FFF0;
    chk({nm, "_words"}, widx_q.size(), 16);
    chk({nm, "_grants"}, addr_q.size(), 16);
    chk({nm, "_req_latency"}, first_req_cyc, exp_req);
    if (addr_q.size() > 0) chk({nm, "_first_addr"}, addr_q[0], first_addr);
    for (int k = 0; k < widx_q.size(); k++) begin
      idx = (first_idx + k) % 16;
      ea = base | idx;
      chk({nm, "_idx"}, widx_q[k], idx);
      chk({nm, "_data"}, wdat_q[k], ea ^ KEY);
      if (k < addr_q.size()) chk({nm, "_addr"}, addr_q[k], ea);
      if (k > 0 && spacing > 0) chk({nm, "_spacing"}, wcyc_q[k] - wcyc_q[k-1], spacing);
    end
    chk({nm, "_done_once"}, done_cnt, 1);
    if (wcyc_q.size() > 0) chk({nm, "_done_after_last"}, done_cyc, wcyc_q[wcyc_q.size()-1] + 1);
  endtask

  task automatic hold_miss_then_release(input string nm);
    int extra = 0;
    repeat (4) begin
      cycle();
      if (mem_req || busy) extra++;
    end
    chk({nm, "_no_retrigger"}, extra, 0);
    chk({nm, "_done_still_once"}, done_cnt, 1);
    miss_cache = 1'b0;
    cycle();
  endtask

  task automatic run_refill(input vec_t v);
    clear_obs();
    gnt_stall = v.gnt_stall;
    rv_dly = v.rv_dly;
    stall_cnt = 0;
    miss_cache = 1'b1;
    ram_address = v.addr;
    exp_req = cyc;
    wait_done(v.name);
    check_line(v.name, v.addr, v.first_idx, v.first_addr, v.spacing);
    hold_miss_then_release(v.name);
  endtask

  initial begin
    vec_t vt[5];
    int n;
    vt[0] = '{"aligned",     32'h0000_0040, 0, 0, 0,  32'h0000_0040, 2};
    vt[1] = '{"crit_first",  32'h0000_004D, 0, 0, 13, 32'h0000_004D, 2};
    vt[2] = '{"gnt_stall",   32'h0000_0123, 3, 0, 3,  32'h0000_0123, 5};
    vt[3] = '{"top_of_mem",  32'hFFFF_FFFF, 0, 1, 15, 32'hFFFF_FFFF, 3};
    vt[4] = '{"after_abort", 32'h0000_0080, 0, 0, 0,  32'h0000_0080, 2};

    // Reset state
    cycle();
    cycle();
    chk("rst_mem_req", int'(mem_req), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_word_ready", int'(word_ready), 0);
    chk("rst_refill_done", int'(refill_done), 0);
    chk("rst_mem_addr", mem_addr, 0);
    rst = 1'b0;
    cycle();
    chk("idle_busy", int'(busy), 0);

    for (int i = 0; i < 4; i++) run_refill(vt[i]);

    // Abort in WAIT after five words; the pending response lands two cycles later
    clear_obs();
    gnt_stall = 0;
    rv_dly = 2;
    stall_cnt = 0;
    miss_cache = 1'b1;
    ram_address = 32'h0000_0300;
    n = 0;
    while (widx_q.size() < 5 && n < 200) begin
      cycle();
      n++;
    end
    chk("abort_pre_words", widx_q.size(), 5);
    cycle();
    miss_cache = 1'b0;
    cycle();
    cycle();
    chk("abort_busy_at_rvalid", int'(busy), 1);
    cycle();
    chk("abort_busy_after", int'(busy), 0);
    repeat (3) cycle();
    chk("abort_words", widx_q.size(), 5);
    chk("abort_no_done", done_cnt, 0);

    run_refill(vt[4]);

    // Asynchronous reset at word seven with a response still in flight
    clear_obs();
    gnt_stall = 0;
    rv_dly = 2;
    stall_cnt = 0;
    miss_cache = 1'b1;
    ram_address = 32'h0000_0205;
    n = 0;
    while (widx_q.size() < 7 && n < 200) begin
      cycle();
      n++;
    end
    chk("mid_pre_words", widx_q.size(), 7);
    cycle();
    chk("mid_pre_busy", int'(busy), 1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", int'(busy), 0);
    chk("mid_rst_mem_req", int'(mem_req), 0);
    chk("mid_rst_mem_addr", mem_addr, 0);
    chk("mid_rst_mem_word", mem_word, 0);
    chk("mid_rst_word_idx", int'(word_idx), 0);
    chk("mid_rst_word_ready", int'(word_ready), 0);
    chk("mid_rst_refill_done", int'(refill_done), 0);
    cycle();
    rst = 1'b0;
    clear_obs();
    exp_req = cyc;
    wait_done("restart");
    check_line("restart", 32'h0000_0205, 5, 32'h0000_0205, 4);
    hold_miss_then_release("restart");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_refill_unit.md
Name: icache_refill_unit

Overview:
Memory-side refill controller for the instruction cache inside fetch_unit.
- Serves `miss_cache`/`ram_address` requests by fetching one full cache line from instruction memory over a request/grant/rvalid bus.
- Delivers the line to the fetch unit word by word on `mem_word`/`word_ready`, critical word first.
- Replaces the behavioural miss model used in unit-level benches, and sits directly upstream of fetch_unit.

Parameters:
ADDR_W, 32, word-address width; equals `pc_size
WORD_W, 32, memory word width; equals `memory_word
LINE_WORDS, 16, words per cache line; power of two, at least 2
IDX_W, $clog2(LINE_WORDS), word-in-line index width (derived, not overridable)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
miss_cache  in  1  fetch unit miss request; level, held high while a refill is wanted
ram_address  in  ADDR_W  word address of the missing instruction; valid while miss_cache is high
mem_word  out  WORD_W  refill word for the cache
word_ready  out  1  one-cycle pulse: mem_word and word_idx are valid
word_idx  out  IDX_W  line slot of mem_word
refill_done  out  1  one-cycle pulse after the last word of a line
busy  out  1  high in any state other than IDLE
mem_req  out  1  memory read request, held until granted
mem_addr  out  ADDR_W  memory word address, stable while mem_req is high
mem_gnt  in  1  memory accepts the request in this cycle
mem_rvalid  in  1  read data valid; one response per grant, in order
mem_rdata  in  WORD_W  read data

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high (`rst`).
- Reset values: state=IDLE; all outputs 0; armed=1; internal counters 0.
- States: IDLE, REQ, WAIT, DRAIN, DONE. All outputs are registered.
- IDLE, when miss_cache=1 and armed=1:
  - Latch base = {ram_address[ADDR_W-1:IDX_W], IDX_W'0}.
  - Latch idx = ram_address[IDX_W-1:0]; cnt=0; armed=0.
  - Next cycle: state REQ, mem_req=1, mem_addr=base|idx.
- armed is set in any cycle where miss_cache=0 is sampled. A held-high miss therefore never retriggers after a completed refill.
- REQ:
  - mem_req and mem_addr hold until mem_gnt.
  - In the grant cycle: next cycle mem_req=0, state WAIT.
- WAIT, on mem_rvalid:
  - Next cycle: word_ready=1, mem_word=mem_rdata, word_idx=idx.
  - idx=(idx+1) mod LINE_WORDS (wraps within the line); cnt++.
  - If cnt was LINE_WORDS-1, go DONE. Otherwise go REQ with mem_req=1 and the new address in the same edge.
- DONE: refill_done=1 for exactly one cycle, then IDLE.
- Latencies:
  - rvalid to word_ready: 1 cycle.
  - Miss to first mem_req: 1 cycle.
  - Best-case spacing of word_ready: every 2 cycles (gnt in the first REQ cycle, rvalid the next cycle).
- Exactly one outstanding memory request at any time.
- Abort: miss_cache=0 sampled in REQ, WAIT or DONE.
  - REQ without gnt in that cycle: mem_req=0 next cycle, go IDLE.
  - REQ with gnt in that cycle, or WAIT without rvalid: go DRAIN. DRAIN discards the single pending response (no word_ready), then goes IDLE.
  - WAIT with rvalid in the same cycle: data discarded, go IDLE.
  - DONE: refill_done still pulses.
  - No refill_done is produced for an aborted line.
- IDLE ignores mem_rvalid.
- Reset mid-refill:
  - All outputs clear immediately (asynchronously).
  - A late mem_rvalid is ignored.
  - armed=1, so a still-high miss_cache starts a fresh refill.
- No word_ready in consecutive cycles; word_ready and refill_done never assert together.

Decomposition:
- Shared constants package:
  - `refill_state_t` enum {IDLE, REQ, WAIT, DRAIN, DONE}.
  - Line-size constant `icache_line_words`, shared with fetch_unit's cache so both agree on LINE_WORDS.
- Width macros `pc_size and `memory_word are reused.
- Single module; no sub-module. The index/counter logic is too small to split.

Test Plan:
- Reset check: assert rst asynchronously mid-cycle -> all outputs 0 before the next edge, busy=0.
- Aligned refill: miss at ram_address=0x40; gnt immediate; rvalid 1 cycle after gnt; rdata=addr^0xA5A5A5A5 -> mem_addr 0x40..0x4F, 16 word_ready pulses, word_idx 0..15, data match; refill_done once, 1 cycle after the 16th word; word_ready every 2 cycles.
- Critical-word first: ram_address=0x4D -> mem_addr order 0x4D,0x4E,0x4F,0x40..0x4C; word_idx 13,14,15,0..12; refill_done after 16 words.
- Grant stall: mem_gnt low 3 cycles per request -> mem_req and mem_addr stable throughout; exactly 16 grants, no duplicate addresses.
- Abort in WAIT after 5 words: miss_cache low, rvalid arrives 2 cycles later -> no word_ready, no refill_done, busy=0 one cycle after rvalid. A new miss at 0x80 then refills 0x80..0x8F correctly.
- Held miss and mid-refill reset:
  - miss_cache kept high after refill_done -> no second refill.
  - Reset at word 7 -> outputs cleared, stale rvalid ignored.
  - After reset release, the refill restarts from the miss address.
